// File: rtl/classify_pkg.sv
// classify_pkg
//   Shared definitions for the instruction classification stage.
//   - 4-bit opcode constants for the CAP2019 base opcode space
//   - one-hot class bit positions (CLS_R, CLS_I, CLS_J, CLS_ILL)
//   - classify_op(): maps an opcode to its one-hot class
package classify_pkg;

  // Base opcode space (low 4 bits of the opcode field)
  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_ADDI = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_LW   = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_XOR  = 4'h6;
  localparam logic [3:0] OP_SW   = 4'h7;
  localparam logic [3:0] OP_BEQ  = 4'h8;
  localparam logic [3:0] OP_BNE  = 4'h9;
  localparam logic [3:0] OP_SLTI = 4'hA;
  localparam logic [3:0] OP_SLT  = 4'hB;
  localparam logic [3:0] OP_ANDI = 4'hC;
  localparam logic [3:0] OP_SLL  = 4'hD;
  localparam logic [3:0] OP_ORI  = 4'hE;
  localparam logic [3:0] OP_JMP  = 4'hF;

  // Bit positions inside the one-hot class vector {ill, j, i, r}
  localparam int CLS_R   = 0;
  localparam int CLS_I   = 1;
  localparam int CLS_J   = 2;
  localparam int CLS_ILL = 3;

  // upper_nz: any opcode bit above bit 3 is set (always illegal).
  // op_lo   : the low four opcode bits.
  function automatic logic [3:0] classify_op(input logic upper_nz, input logic [3:0] op_lo);
    logic [3:0] cls;
    cls = 4'b0000;
    if (upper_nz) begin
      cls[CLS_ILL] = 1'b1;
    end else begin
      case (op_lo)
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT, OP_SLL:
          cls[CLS_R] = 1'b1;
        OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_SLTI, OP_ANDI, OP_ORI:
          cls[CLS_I] = 1'b1;
        OP_JMP:
          cls[CLS_J] = 1'b1;
        default:
          cls[CLS_ILL] = 1'b1;
      endcase
    end
    return cls;
  endfunction

endpackage

// File: rtl/classify_skid_buf.sv
// classify_skid_buf
//   Generic two-entry elastic buffer (head + skid) with valid/ready on both
//   sides and a synchronous flush. Strictly FIFO; in_ready depends only on
//   registered state (plus rst/flush gating), never on out_ready.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   flush                discard both entries at the next edge
//   in_valid/in_ready    upstream handshake, in_data payload
//   out_valid/out_ready  downstream handshake, out_data payload (head entry)
module classify_skid_buf #(
  parameter int DATA_W = 36
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);

  logic              head_valid_q, head_valid_d;
  logic [DATA_W-1:0] head_data_q,  head_data_d;
  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] skid_data_q,  skid_data_d;
  logic              accept;
  logic              retire;

  // Ready is simply "skid is free"; no acceptance during reset or flush.
  assign in_ready  = !rst && !flush && !skid_valid_q;
  assign out_valid = head_valid_q;
  assign out_data  = head_data_q;

  assign accept = in_valid && in_ready;
  assign retire = head_valid_q && out_ready;

  always_comb begin
    head_valid_d = head_valid_q;
    head_data_d  = head_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (flush) begin
      head_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (retire) begin
      if (skid_valid_q) begin
        // Skid refills head; no accept is possible because in_ready was low.
        head_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        head_data_d = in_data;
      end else begin
        head_valid_d = 1'b0;
      end
    end else if (accept) begin
      if (!head_valid_q) begin
        head_valid_d = 1'b1;
        head_data_d  = in_data;
      end else begin
        // Head is stalled: park the new word in the skid register.
        skid_valid_d = 1'b1;
        skid_data_d  = in_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_valid_q <= 1'b0;
      head_data_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
    end else begin
      head_valid_q <= head_valid_d;
      head_data_q  <= head_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
    end
  end

endmodule

// File: rtl/instr_classify_stage.sv
// instr_classify_stage
//   Registered fetch->decode stage that tags each instruction word as R, I,
//   J or illegal (one-hot {ill, j, i, r}) at acceptance, then forwards word
//   and tag through a two-entry elastic buffer.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   flush                     discard all buffered words
//   in_valid/in_ready/in_instr      upstream handshake and word
//   out_valid/out_ready/out_instr   downstream handshake and word
//   out_class                 one-hot class of out_instr
//   cnt_r/cnt_i/cnt_j/cnt_ill saturating retire counters per class
// Build option:
//   CLASSIFY_STATS_EN - when defined, the four counters and their ports exist.
module instr_classify_stage
  import classify_pkg::*;
#(
  parameter int INSTR_W  = 32,
  parameter int OPCODE_W = 6,
  parameter int CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [3:0]         out_class
`ifdef CLASSIFY_STATS_EN
  ,
  output logic [CNT_W-1:0]   cnt_r,
  output logic [CNT_W-1:0]   cnt_i,
  output logic [CNT_W-1:0]   cnt_j,
  output logic [CNT_W-1:0]   cnt_ill
`endif
);

  localparam int PAY_W = INSTR_W + 4;

  // Elaboration-time parameter sanity.
  if (OPCODE_W < 4)       begin : g_bad_opw   $error("OPCODE_W must be >= 4"); end
  if (INSTR_W < OPCODE_W) begin : g_bad_instw $error("INSTR_W must be >= OPCODE_W"); end
  if (CNT_W < 1)          begin : g_bad_cntw  $error("CNT_W must be >= 1"); end

  logic [OPCODE_W-1:0] op;
  logic                upper_nz;
  logic [3:0]          in_class;
  logic [PAY_W-1:0]    buf_in_data;
  logic [PAY_W-1:0]    buf_out_data;

  assign op = in_instr[INSTR_W-1 -: OPCODE_W];

  // Opcodes wider than 4 bits are illegal whenever an upper bit is set.
  if (OPCODE_W > 4) begin : g_upper
    assign upper_nz = |op[OPCODE_W-1:4];
  end else begin : g_no_upper
    assign upper_nz = 1'b0;
  end

  assign in_class    = classify_op(upper_nz, op[3:0]);
  assign buf_in_data = {in_instr, in_class};

  classify_skid_buf #(
    .DATA_W(PAY_W)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (buf_in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (buf_out_data)
  );

  assign out_instr = buf_out_data[PAY_W-1:4];
  assign out_class = buf_out_data[3:0];

`ifdef CLASSIFY_STATS_EN
  // A retire coinciding with flush is discarded and not counted.
  logic                  retire_cnt;
  logic [3:0][CNT_W-1:0] cnt_all;

  assign retire_cnt = out_valid && out_ready && !flush;

  for (genvar gi = 0; gi < 4; gi++) begin : g_cnt
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
      cnt_d = cnt_q;
      if (retire_cnt && out_class[gi] && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
    end

    assign cnt_all[gi] = cnt_q;
  end

  assign cnt_r   = cnt_all[CLS_R];
  assign cnt_i   = cnt_all[CLS_I];
  assign cnt_j   = cnt_all[CLS_J];
  assign cnt_ill = cnt_all[CLS_ILL];
`endif

endmodule

// File: tb/tb_instr_classify_stage.sv
module tb_instr_classify_stage;

  localparam int INSTR_W  = 32;
  localparam int OPCODE_W = 6;
  localparam int CNT_W    = 4;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               flush = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [INSTR_W-1:0] in_instr = '0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [INSTR_W-1:0] out_instr;
  logic [3:0]         out_class;
`ifdef CLASSIFY_STATS_EN
  logic [CNT_W-1:0]   cnt_r, cnt_i, cnt_j, cnt_ill;
`endif

  int n_checks = 0;
  int n_errors = 0;

  instr_classify_stage #(
    .INSTR_W(INSTR_W), .OPCODE_W(OPCODE_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_class(out_class)
`ifdef CLASSIFY_STATS_EN
    , .cnt_r(cnt_r), .cnt_i(cnt_i), .cnt_j(cnt_j), .cnt_ill(cnt_ill)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Independent reference classification from the opcode tables.
  function automatic logic [3:0] exp_class(input logic [OPCODE_W-1:0] op);
    if (op[OPCODE_W-1:4] != 0) return 4'b1000;
    case (op[3:0])
      4'h0, 4'h2, 4'h4, 4'h5, 4'h6, 4'hB, 4'hD: return 4'b0001;
      4'hF:                                     return 4'b0100;
      default:                                  return 4'b0010;
    endcase
  endfunction

  function automatic logic [INSTR_W-1:0] mk_word(input logic [OPCODE_W-1:0] op);
    logic [INSTR_W-OPCODE_W-1:0] rest;
    rest = (INSTR_W-OPCODE_W)'($urandom);
    return {op, rest};
  endfunction

  // Scoreboard: pushed on acceptance, popped on retire.
  typedef struct {
    logic [INSTR_W-1:0] instr;
    logic [3:0]         cls;
  } exp_t;
  exp_t sb_q[$];
  int   m_cnt[4];

  always @(posedge clk or posedge rst) begin : monitor
    exp_t e;
    if (rst) begin
      sb_q.delete();
      for (int k = 0; k < 4; k++) m_cnt[k] <= 0;
    end else if (flush) begin
      sb_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check("sb_unexpected_out", 64'(out_instr), 64'hDEAD);
        end else begin
          e = sb_q.pop_front();
          check("sb_instr", 64'(out_instr), 64'(e.instr));
          check("sb_class", 64'(out_class), 64'(e.cls));
          for (int k = 0; k < 4; k++)
            if (e.cls[k] && m_cnt[k] < CNT_MAX) m_cnt[k] <= m_cnt[k] + 1;
        end
      end
      if (in_valid && in_ready) begin
        e.instr = in_instr;
        e.cls   = exp_class(in_instr[INSTR_W-1 -: OPCODE_W]);
        sb_q.push_back(e);
      end
    end
  end

  task automatic check_counters(input string tag);
`ifdef CLASSIFY_STATS_EN
    check({tag, "_cnt_r"},   64'(cnt_r),   64'(m_cnt[0]));
    check({tag, "_cnt_i"},   64'(cnt_i),   64'(m_cnt[1]));
    check({tag, "_cnt_j"},   64'(cnt_j),   64'(m_cnt[2]));
    check({tag, "_cnt_ill"}, 64'(cnt_ill), 64'(m_cnt[3]));
`else
    check({tag, "_scoreboard_empty"}, 64'(sb_q.size()), 64'd0);
`endif
  endtask

  task automatic drain(input string tag);
    int budget;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    budget = 0;
    while ((out_valid || sb_q.size() != 0) && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    check({tag, "_drain_done"}, 64'(out_valid || sb_q.size() != 0), 64'd0);
  endtask

  logic [OPCODE_W-1:0] dir_ops [4];
  logic [3:0]          dir_cls [4];
  logic [INSTR_W-1:0]  w0, w1, w2;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // ---------------- reset state ----------------
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd0);
    check("rst_out_instr", 64'(out_instr), 64'd0);
    check("rst_out_class", 64'(out_class), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    check_counters("rst");

    // ---------------- directed class stream ----------------
    dir_ops[0] = 6'h00; dir_cls[0] = 4'b0001;
    dir_ops[1] = 6'h01; dir_cls[1] = 4'b0010;
    dir_ops[2] = 6'h0F; dir_cls[2] = 4'b0100;
    dir_ops[3] = 6'h10; dir_cls[3] = 4'b1000;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_instr = mk_word(dir_ops[k]);
      w0 = in_instr;
      @(negedge clk);
      check($sformatf("dir%0d_valid", k), 64'(out_valid), 64'd1);
      check($sformatf("dir%0d_class", k), 64'(out_class), 64'(dir_cls[k]));
      check($sformatf("dir%0d_instr", k), 64'(out_instr), 64'(w0));
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("dir_idle_valid", 64'(out_valid), 64'd0);

    // ---------------- stall with back-pressure ----------------
    out_ready = 1'b0;
    in_valid  = 1'b1;
    w0 = mk_word(6'h02); in_instr = w0;
    @(negedge clk);                       // w0 -> head
    check("stall_c1_ready", 64'(in_ready), 64'd1);
    w1 = mk_word(6'h03); in_instr = w1;
    @(negedge clk);                       // w1 -> skid
    check("stall_c2_ready", 64'(in_ready), 64'd0);
    w2 = mk_word(6'h0F); in_instr = w2;   // held until accepted
    @(negedge clk);
    check("stall_hold_instr", 64'(out_instr), 64'(w0));
    check("stall_hold_ready", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    @(negedge clk);                       // w0 retires, w1 -> head
    check("stall_rel1_instr", 64'(out_instr), 64'(w1));
    check("stall_rel1_ready", 64'(in_ready), 64'd1);
    @(negedge clk);                       // w1 retires, w2 -> head
    check("stall_rel2_instr", 64'(out_instr), 64'(w2));
    for (int k = 0; k < 4; k++) begin     // back to 1 word/cycle
      in_instr = mk_word(6'(k + 4));
      w0 = in_instr;
      @(negedge clk);
      check($sformatf("stall_tput%0d", k), 64'(out_instr), 64'(w0));
    end
    drain("stall");
    check_counters("stall");

    // ---------------- flush with both entries full ----------------
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = mk_word(6'h00);
    @(negedge clk);
    in_instr  = mk_word(6'h01);
    @(negedge clk);
    check("flush_pre_full", 64'(in_ready), 64'd0);
    flush     = 1'b1;
    out_ready = 1'b1;
    in_instr  = mk_word(6'h0F);
    #1;
    check("flush_cycle_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    #1;
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_in_ready",  64'(in_ready),  64'd1);
    check_counters("flush");

    // ---------------- counter saturation (20 R-type) ----------------
    rst = 1'b1;
    #2;
    rst = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int k = 0; k < 20; k++) begin
      in_instr = mk_word(6'(k % 2 == 0 ? 4'h0 : 4'hD));
      @(negedge clk);
    end
    drain("sat");
`ifdef CLASSIFY_STATS_EN
    check("sat_cnt_r",   64'(cnt_r),   64'd15);
    check("sat_cnt_i",   64'(cnt_i),   64'd0);
    check("sat_cnt_j",   64'(cnt_j),   64'd0);
    check("sat_cnt_ill", 64'(cnt_ill), 64'd0);
`endif

    // ---------------- asynchronous reset mid-operation ----------------
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = mk_word(6'h0F);
    @(negedge clk);
    in_valid = 1'b0;
    check("arst_pre_valid", 64'(out_valid), 64'd1);
    #1;
    rst = 1'b1;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_out_class", 64'(out_class), 64'd0);
    check("arst_in_ready",  64'(in_ready),  64'd0);
`ifdef CLASSIFY_STATS_EN
    check("arst_cnt_r", 64'(cnt_r), 64'd0);
`endif
    @(negedge clk);
    rst = 1'b0;

    // ---------------- random traffic, 10k words ----------------
    begin
      int  sent;
      bit  have;
      logic [INSTR_W-1:0] w;
      logic [OPCODE_W-1:0] op;
      sent = 0;
      have = 1'b0;
      w = '0;
      while (sent < 10000) begin
        @(negedge clk);
        if (!have && $urandom_range(0, 9) < 7) begin
          op = ($urandom_range(0, 4) == 0) ? OPCODE_W'($urandom_range(0, 63))
                                           : OPCODE_W'($urandom_range(0, 15));
          w = mk_word(op);
          have = 1'b1;
        end
        in_valid  = have;
        in_instr  = have ? w : INSTR_W'($urandom);
        out_ready = ($urandom_range(0, 9) < 7);
        #1;
        if (have && in_ready) begin
          sent++;
          have = 1'b0;
        end
      end
      @(negedge clk);
    end
    drain("rand");
    check_counters("rand");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
